// File: rtl/mcu_spi_tx_ctrl_if.sv
// mcu_spi_tx_ctrl_if
//   Bundles the FPGA-side write port, the MCU chip-select input and the
//   shift-register / MCU handshake outputs of mcu_spi_tx_ctrl.
//   master : producer side (FPGA logic / MCU model) - drives wr_en, wr_data, mcu_cs_n
//   slave  : the controller - drives full, data_load, load, transmit, data_ready, overflow
interface mcu_spi_tx_ctrl_if;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        mcu_cs_n;
    logic [15:0] data_load;
    logic        load;
    logic        transmit;
    logic        data_ready;
    logic        overflow;

    modport master (
        output wr_en, wr_data, mcu_cs_n,
        input  full, data_load, load, transmit, data_ready, overflow
    );

    modport slave (
        input  wr_en, wr_data, mcu_cs_n,
        output full, data_load, load, transmit, data_ready, overflow
    );
endinterface

// File: rtl/mcu_spi_tx_ctrl.sv
// mcu_spi_tx_ctrl
//   Feeds 16-bit words from FPGA logic to the MCU-facing SPI output shift
//   register. Words are buffered in a DEPTH-entry FIFO; one word at a time is
//   popped into data_load with a one-cycle load strobe, data_ready is raised to
//   the MCU, and transmit is held for the accepted chip-select frame.
//   Ports:
//     fpga_sck  : clock, all state on the rising edge
//     reset     : asynchronous, active-high
//     bus.slave : wr_en/wr_data/full/overflow (write side), mcu_cs_n (async
//                 MCU chip select), data_load/load/transmit/data_ready (outputs)
module mcu_spi_tx_ctrl #(
    parameter int DEPTH   = 4,
    parameter int SYNC_FF = 2
) (
    input  logic             fpga_sck,
    input  logic             reset,
    mcu_spi_tx_ctrl_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, READY, XFER, DONE} state_t;

    state_t            state;
    logic [15:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [SYNC_FF-1:0] cs_sync;
    logic              cs_d;
    logic              cs_s, cs_fall, cs_rise;
    logic              full_w, push, pop;
    logic [15:0]       data_load_q;
    logic              load_q, transmit_q, ready_q, overflow_q;

    // full is judged on the registered count, so a push into a full FIFO is
    // dropped even when the same cycle pops a word.
    assign full_w = (count == CW'(DEPTH));
    assign push   = bus.wr_en && !full_w;
    assign pop    = (state == IDLE) && (count != '0);

    // Chip-select synchroniser, preset to 1 so reset looks like an idle CS.
    assign cs_s    = cs_sync[SYNC_FF-1];
    assign cs_fall = cs_d && !cs_s;
    assign cs_rise = !cs_d && cs_s;

    always_ff @(posedge fpga_sck or posedge reset) begin
        if (reset) begin
            cs_sync <= '1;
            cs_d    <= 1'b1;
        end else begin
            cs_sync <= {cs_sync[SYNC_FF-2:0], bus.mcu_cs_n};
            cs_d    <= cs_s;
        end
    end

    // Storage array carries no reset; validity is tracked by count.
    always_ff @(posedge fpga_sck) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge fpga_sck or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (bus.wr_en && full_w) overflow_q <= 1'b1;
        end
    end

    // Outputs are registered alongside the state they belong to. Only edges
    // seen while in READY start a frame, so a frame already in progress when
    // the word arrives is never joined half way.
    always_ff @(posedge fpga_sck or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            data_load_q <= '0;
            load_q      <= 1'b0;
            transmit_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (count != '0) begin
                    state       <= LOAD;
                    data_load_q <= mem[rd_ptr];
                    load_q      <= 1'b1;
                end
                LOAD: begin
                    state   <= READY;
                    load_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                READY: if (cs_fall) begin
                    state      <= XFER;
                    transmit_q <= 1'b1;
                end
                XFER: if (cs_rise) begin
                    state      <= DONE;
                    transmit_q <= 1'b0;
                    ready_q    <= 1'b0;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.full       = full_w;
    assign bus.overflow   = overflow_q;
    assign bus.data_load  = data_load_q;
    assign bus.load       = load_q;
    assign bus.transmit   = transmit_q;
    assign bus.data_ready = ready_q;

endmodule

// File: tb/tb_mcu_spi_tx_ctrl.sv
module tb_mcu_spi_tx_ctrl;
    localparam int DEPTH   = 4;
    localparam int SYNC_FF = 2;

    logic fpga_sck;
    logic reset;
    mcu_spi_tx_ctrl_if bus();

    mcu_spi_tx_ctrl #(.DEPTH(DEPTH), .SYNC_FF(SYNC_FF)) dut (
        .fpga_sck (fpga_sck),
        .reset    (reset),
        .bus      (bus)
    );

    initial fpga_sck = 1'b0;
    always #5 fpga_sck = ~fpga_sck;

    int checks = 0;
    int errors = 0;

    // Downstream shift register: captures data_load on the load strobe.
    logic [15:0] tb_cap = '0;
    always @(posedge fpga_sck) if (bus.load) tb_cap <= bus.data_load;

    // Sticky flag: a reload while shifting would corrupt the frame.
    logic overlap_seen = 1'b0;
    always @(negedge fpga_sck) if (bus.load && bus.transmit) overlap_seen <= 1'b1;

    typedef struct {
        logic        wr;
        logic [15:0] wd;
        logic        cs;
        logic        ld;
        logic        rdy;
        logic        tx;
        logic [15:0] dl;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge fpga_sck);
        @(negedge fpga_sck);
    endtask

    task automatic push(input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // One MCU frame of 16 SCK periods honouring the CS setup/hold contract.
    // rx collects MSB-first bits shifted while transmit is high.
    task automatic frame(input int post, output logic [15:0] rx, output int txc);
        logic [15:0] sr;
        bus.mcu_cs_n = 1'b0;
        repeat (SYNC_FF + 2) tick();
        sr  = tb_cap;
        rx  = '0;
        txc = 0;
        for (int b = 0; b < 16; b++) begin
            if (bus.transmit) begin
                rx  = {rx[14:0], sr[15]};
                sr  = {sr[14:0], 1'b0};
                txc++;
            end
            tick();
        end
        repeat (SYNC_FF + 2) tick();
        bus.mcu_cs_n = 1'b1;
        repeat (post) tick();
    endtask

    initial begin
        logic [15:0] rx;
        int          txc;
        logic [15:0] exp4 [5];
        logic [15:0] q [$];
        logic        ovf_m;
        logic [15:0] d;

        //             wr    wd        cs    ld    rdy   tx    dl
        tbl[0]  = '{1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA5C3};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'hA5C3};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA5C3};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA5C3};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA5C3};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA5C3};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA5C3};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA5C3};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA5C3};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA5C3};

        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.mcu_cs_n = 1'b1;
        tick(); tick();
        chk("rst load",      bus.load,       0);
        chk("rst transmit",  bus.transmit,   0);
        chk("rst data_ready",bus.data_ready, 0);
        chk("rst overflow",  bus.overflow,   0);
        chk("rst full",      bus.full,       0);
        chk("rst data_load", bus.data_load,  0);
        reset = 1'b0;
        tick();

        // Single word: cycle-exact latency of load, data_ready and transmit.
        for (int i = 0; i < 11; i++) begin
            bus.wr_en    = tbl[i].wr;
            bus.wr_data  = tbl[i].wd;
            bus.mcu_cs_n = tbl[i].cs;
            tick();
            chk($sformatf("vec%0d load", i),       bus.load,       tbl[i].ld);
            chk($sformatf("vec%0d data_ready", i), bus.data_ready, tbl[i].rdy);
            chk($sformatf("vec%0d transmit", i),   bus.transmit,   tbl[i].tx);
            chk($sformatf("vec%0d data_load", i),  bus.data_load,  tbl[i].dl);
        end
        bus.wr_en = 1'b0;
        tick();

        // Full 16-bit frame delivers the word MSB first.
        push(16'hA5C3);
        repeat (3) tick();
        frame(SYNC_FF + 1, rx, txc);
        chk("t1 rx", rx, 16'hA5C3);
        chk("t1 tx cycles", txc, 16);
        chk("t1 ready after cs", bus.data_ready, 0);
        repeat (3) tick();

        // Fill: the first word moves to the holding register, so five
        // back-to-back pushes fill the FIFO and the sixth overflows.
        for (int i = 1; i <= 6; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 16'(i);
            tick();
            if (i == 4) chk("t2 full after 4", bus.full, 0);
            if (i == 5) begin
                chk("t2 full after 5", bus.full, 1);
                chk("t2 ovf after 5",  bus.overflow, 0);
            end
        end
        bus.wr_en = 1'b0;
        chk("t2 ovf after 6",  bus.overflow, 1);
        chk("t2 full after 6", bus.full, 1);
        for (int i = 1; i <= 5; i++) begin
            frame(SYNC_FF + 3, rx, txc);
            chk($sformatf("t2 rx%0d", i), rx, 16'(i));
            chk($sformatf("t2 tx%0d", i), txc, 16);
        end
        repeat (2) tick();
        chk("t2 drained ready", bus.data_ready, 0);
        frame(SYNC_FF + 3, rx, txc);
        chk("t2 dropped word not offered", txc, 0);

        // Frame opened while empty is ignored even once a word arrives in it.
        bus.mcu_cs_n = 1'b0;
        repeat (4) tick();
        push(16'h1234);
        txc = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.transmit) txc++;
            tick();
        end
        chk("t3 tx in unaccepted frame", txc, 0);
        chk("t3 ready mid frame", bus.data_ready, 1);
        bus.mcu_cs_n = 1'b1;
        repeat (SYNC_FF + 3) tick();
        frame(SYNC_FF + 3, rx, txc);
        chk("t3 rx", rx, 16'h1234);
        chk("t3 tx cycles", txc, 16);

        // Push coinciding with the IDLE pop of the single FIFO entry.
        repeat (2) tick();
        push(16'h1111);
        repeat (3) tick();
        push(16'h2222);
        frame(0, rx, txc);
        chk("t4 rx first", rx, 16'h1111);
        repeat (SYNC_FF + 1) tick();
        chk("t4 ready low in DONE", bus.data_ready, 0);
        tick();
        push(16'h3333);
        chk("t4 pop coincides load", bus.load, 1);
        chk("t4 pop coincides data", bus.data_load, 16'h2222);
        push(16'h4444);
        push(16'h5555);
        chk("t4 full at 3", bus.full, 0);
        push(16'h6666);
        chk("t4 full at 4", bus.full, 1);
        exp4 = '{16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        // Drained with minimum CS-high spacing between frames.
        for (int i = 0; i < 5; i++) begin
            frame(SYNC_FF + 3, rx, txc);
            chk($sformatf("t4 rx%0d", i), rx, exp4[i]);
            chk($sformatf("t4 tx%0d", i), txc, 16);
        end

        // Reset in the middle of a transfer; overflow is still set from the fill.
        push(16'hBEEF);
        push(16'hCAFE);
        repeat (3) tick();
        bus.mcu_cs_n = 1'b0;
        repeat (5) tick();
        chk("t5 tx before reset", bus.transmit, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5 async load",       bus.load,       0);
        chk("t5 async transmit",   bus.transmit,   0);
        chk("t5 async data_ready", bus.data_ready, 0);
        chk("t5 async overflow",   bus.overflow,   0);
        chk("t5 async full",       bus.full,       0);
        chk("t5 async data_load",  bus.data_load,  0);
        @(negedge fpga_sck);
        reset = 1'b0;
        bus.mcu_cs_n = 1'b1;
        repeat (6) tick();
        chk("t5 fifo empty", bus.data_ready, 0);
        push(16'h5A5A);
        repeat (3) tick();
        frame(SYNC_FF + 3, rx, txc);
        chk("t5 rx after reset", rx, 16'h5A5A);
        chk("t5 tx after reset", txc, 16);

        // Random pushes and frames against a word-level queue model:
        // capacity is the FIFO plus the one word held in data_load.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        ovf_m = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                d = 16'($urandom);
                push(d);
                repeat (4) tick();
                if (q.size() < DEPTH + 1) q.push_back(d);
                else ovf_m = 1'b1;
                chk($sformatf("rnd%0d full", n),     bus.full,       (q.size() == DEPTH + 1));
                chk($sformatf("rnd%0d overflow", n), bus.overflow,   ovf_m);
                chk($sformatf("rnd%0d ready", n),    bus.data_ready, (q.size() != 0));
            end else begin
                frame(SYNC_FF + 3, rx, txc);
                repeat (2) tick();
                if (q.size() != 0) begin
                    chk($sformatf("rnd%0d rx", n), rx, q.pop_front());
                    chk($sformatf("rnd%0d tx", n), txc, 16);
                end else begin
                    chk($sformatf("rnd%0d idle tx", n), txc, 0);
                end
            end
        end

        chk("no load while transmit", overlap_seen, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
